// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, reset level and aluop codes.
// The helpers classify memory ops and give the number of bytes each op moves.
package mem_access_pkg;

  localparam int unsigned RegWidth   = 32;
  localparam int unsigned AluOpWidth = 8;
  localparam logic        RstEnable  = 1'b1;

  typedef logic [RegWidth-1:0]   reg_bus_t;
  typedef logic [AluOpWidth-1:0] alu_op_bus_t;

  localparam alu_op_bus_t AluOpNop  = 8'h00;
  localparam alu_op_bus_t AluOpAddi = 8'h01;
  localparam alu_op_bus_t AluOpLb   = 8'h20;
  localparam alu_op_bus_t AluOpLh   = 8'h21;
  localparam alu_op_bus_t AluOpLw   = 8'h22;
  localparam alu_op_bus_t AluOpLbu  = 8'h24;
  localparam alu_op_bus_t AluOpLhu  = 8'h25;
  localparam alu_op_bus_t AluOpSb   = 8'h28;
  localparam alu_op_bus_t AluOpSh   = 8'h29;
  localparam alu_op_bus_t AluOpSw   = 8'h2a;

  // Zero for non-memory ops, so it doubles as the memory-op decode.
  function automatic logic [2:0] byte_count(alu_op_bus_t op);
    case (op)
      AluOpLb, AluOpLbu, AluOpSb: return 3'd1;
      AluOpLh, AluOpLhu, AluOpSh: return 3'd2;
      AluOpLw, AluOpSw:           return 3'd4;
      default:                    return 3'd0;
    endcase
  endfunction

  function automatic logic is_mem_op(alu_op_bus_t op);
    return byte_count(op) != 3'd0;
  endfunction

  function automatic logic is_store(alu_op_bus_t op);
    return (op == AluOpSb) || (op == AluOpSh) || (op == AluOpSw);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide request/ack bus between the memory-access stage and the memory controller.
// The stage is master; the controller answers with a one-cycle ack carrying load data.
interface mem_access_if;
  import mem_access_pkg::*;

  logic     req;
  logic     we;
  reg_bus_t addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic     ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: splits loads/stores into byte transfers, stalls upstream
// while busy and presents the assembled, extended load result for one cycle.
module mem_access
  import mem_access_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rd_i,
  input  logic         wreg_i,
  input  reg_bus_t     wdata_i,
  input  reg_bus_t     mem_addr_i,
  input  alu_op_bus_t  aluop_i,
  input  reg_bus_t     reg2_i,
  output logic [4:0]   rd_o,
  output logic         wreg_o,
  output reg_bus_t     wdata_o,
  output logic         stall_req_o,
  mem_access_if.master mem
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  alu_op_bus_t op_q;
  reg_bus_t    reg2_q;
  logic [4:0]  rd_q;
  logic        wreg_q;
  logic [2:0]  cnt_q;
  reg_bus_t    result_q;
  logic        req_q;
  logic        we_q;
  reg_bus_t    addr_q;
  logic [7:0]  wdata_q;

  logic [2:0]  cnt_nxt;
  reg_bus_t    reg2_shift;
  logic        last_byte;
  reg_bus_t    load_data;

  assign cnt_nxt    = cnt_q + 3'd1;
  assign reg2_shift = reg2_q >> {cnt_nxt[1:0], 3'b000};
  assign last_byte  = (cnt_q == byte_count(op_q) - 3'd1);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= StIdle;
      op_q     <= AluOpNop;
      reg2_q   <= '0;
      rd_q     <= '0;
      wreg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_mem_op(aluop_i)) begin
            op_q     <= aluop_i;
            reg2_q   <= reg2_i;
            rd_q     <= rd_i;
            wreg_q   <= wreg_i;
            cnt_q    <= '0;
            result_q <= '0;
            req_q    <= 1'b1;
            we_q     <= is_store(aluop_i);
            addr_q   <= mem_addr_i;
            wdata_q  <= reg2_i[7:0];
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          // Request fields are only advanced on ack, so they hold steady while waiting.
          if (mem.ack) begin
            if (!is_store(op_q)) begin
              result_q[{cnt_q[1:0], 3'b000} +: 8] <= mem.rdata;
            end
            cnt_q <= cnt_nxt;
            if (last_byte) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              state_q <= StDone;
            end else begin
              addr_q  <= addr_q + 32'd1;
              wdata_q <= reg2_shift[7:0];
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    load_data = result_q;
    case (op_q)
      AluOpLb:  load_data = {{24{result_q[7]}}, result_q[7:0]};
      AluOpLh:  load_data = {{16{result_q[15]}}, result_q[15:0]};
      AluOpLbu: load_data = {24'b0, result_q[7:0]};
      AluOpLhu: load_data = {16'b0, result_q[15:0]};
      default:  load_data = result_q;
    endcase
  end

  always_comb begin
    rd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    if (rst != RstEnable) begin
      case (state_q)
        StIdle: begin
          if (is_mem_op(aluop_i)) begin
            stall_req_o = 1'b1;
          end else begin
            rd_o    = rd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        StBusy: stall_req_o = 1'b1;
        StDone: begin
          rd_o = rd_q;
          if (!is_store(op_q)) begin
            wreg_o  = wreg_q;
            wdata_o = load_data;
          end
        end
        default: stall_req_o = 1'b0;
      endcase
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = (rst == RstEnable) ? '0 : addr_q;
  assign mem.wdata = (rst == RstEnable) ? '0 : wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random ops against a byte-array
// memory model with configurable ack delay and an access log.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_in;
  logic        wreg_in;
  logic [31:0] wdata_in;
  logic [31:0] addr_in;
  alu_op_bus_t aluop;
  logic [31:0] reg2_in;
  logic [4:0]  rd_out;
  logic        wreg_out;
  logic [31:0] wdata_out;
  logic        stall;

  always #5 clk = ~clk;

  mem_access_if mem_bus ();

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .rd_i       (rd_in),
    .wreg_i     (wreg_in),
    .wdata_i    (wdata_in),
    .mem_addr_i (addr_in),
    .aluop_i    (aluop),
    .reg2_i     (reg2_in),
    .rd_o       (rd_out),
    .wreg_o     (wreg_out),
    .wdata_o    (wdata_out),
    .stall_req_o(stall),
    .mem        (mem_bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem_model [logic [31:0]];
  acc_t acc_log [$];
  int ack_delay = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  function automatic int nbytes_of(input alu_op_bus_t op);
    case (op)
      AluOpLb, AluOpLbu, AluOpSb: return 1;
      AluOpLh, AluOpLhu, AluOpSh: return 2;
      AluOpLw, AluOpSw:           return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit store_op(input alu_op_bus_t op);
    return (op == AluOpSb) || (op == AluOpSh) || (op == AluOpSw);
  endfunction

  // Little-endian value of the bytes in memory, then signed reinterpretation for LB/LH.
  function automatic logic [31:0] ref_load(input alu_op_bus_t op, input logic [31:0] a);
    longint v = 0;
    longint w = 1;
    for (int i = 0; i < nbytes_of(op); i++) begin
      v += longint'(get_byte(a + 32'(i))) * w;
      w *= 256;
    end
    if (op == AluOpLb && v >= 128) v -= 256;
    if (op == AluOpLh && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  // Memory controller model: acks after ack_delay wait cycles, random ack noise when idle.
  initial begin
    logic [31:0] held_addr;
    int wait_cnt;
    held_addr = '0;
    wait_cnt = 0;
    mem_bus.ack = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_bus.req && !rst) begin
        if (wait_cnt > 0) check_eq("addr_stable", mem_bus.addr, held_addr);
        else held_addr = mem_bus.addr;
        if (wait_cnt >= ack_delay) begin
          mem_bus.ack = 1'b1;
          if (mem_bus.we) begin
            mem_model[mem_bus.addr] = mem_bus.wdata;
            acc_log.push_back('{mem_bus.addr, 1'b1, mem_bus.wdata});
          end else begin
            mem_bus.rdata = get_byte(mem_bus.addr);
            acc_log.push_back('{mem_bus.addr, 1'b0, mem_bus.rdata});
          end
          wait_cnt = 0;
        end else begin
          mem_bus.ack = 1'b0;
          mem_bus.rdata = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        mem_bus.ack = 1'($urandom_range(0, 1));
        mem_bus.rdata = 8'($urandom);
      end
    end
  end

  task automatic run_op(input alu_op_bus_t op, input logic [31:0] a, input logic [31:0] r2,
                        input logic [4:0] rd, input logic w, input logic [31:0] wd, input int d);
    int n;
    int stalls;
    bit done;
    bit busy_leak;
    logic [31:0] exp_data;
    n = nbytes_of(op);
    ack_delay = d;
    acc_log.delete();
    @(posedge clk);
    #1;
    aluop = op;
    addr_in = a;
    reg2_in = r2;
    rd_in = rd;
    wreg_in = w;
    wdata_in = wd;
    @(negedge clk);
    if (n == 0) begin
      check_eq("pass_rd", 32'(rd_out), 32'(rd));
      check_eq("pass_wreg", 32'(wreg_out), 32'(w));
      check_eq("pass_wdata", wdata_out, wd);
      check_eq("pass_stall", 32'(stall), 32'd0);
      check_eq("pass_req", 32'(mem_bus.req), 32'd0);
      return;
    end
    check_eq("start_stall", 32'(stall), 32'd1);
    check_eq("start_wreg", 32'(wreg_out), 32'd0);
    stalls = 1;
    done = 1'b0;
    busy_leak = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (wreg_out || rd_out != 5'd0 || wdata_out != 32'd0 || !mem_bus.req) busy_leak = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
    check_eq("done_reached", 32'(done), 32'd1);
    check_eq("busy_outputs", 32'(busy_leak), 32'd0);
    check_eq("stall_cycles", 32'(stalls), 32'(1 + n * (d + 1)));
    check_eq("access_count", 32'(acc_log.size()), 32'(n));
    for (int i = 0; i < n && i < acc_log.size(); i++) begin
      check_eq("acc_addr", acc_log[i].addr, a + 32'(i));
      check_eq("acc_we", 32'(acc_log[i].we), 32'(store_op(op)));
      if (store_op(op)) check_eq("acc_wdata", 32'(acc_log[i].data), (r2 >> (8 * i)) & 32'hff);
    end
    exp_data = store_op(op) ? 32'd0 : ref_load(op, a);
    check_eq("done_wdata", wdata_out, exp_data);
    check_eq("done_wreg", 32'(wreg_out), store_op(op) ? 32'd0 : 32'(w));
    check_eq("done_rd", 32'(rd_out), 32'(rd));
    check_eq("done_req", 32'(mem_bus.req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_op_bus_t ops [9];
    alu_op_bus_t op;
    logic [31:0] a;
    ops = '{AluOpLb, AluOpLh, AluOpLw, AluOpLbu, AluOpLhu, AluOpSb, AluOpSh, AluOpSw, AluOpAddi};
    rst = 1'b1;
    aluop = AluOpNop;
    addr_in = '0;
    reg2_in = '0;
    rd_in = '0;
    wreg_in = 1'b0;
    wdata_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_req", 32'(mem_bus.req), 32'd0);
    check_eq("rst_we", 32'(mem_bus.we), 32'd0);
    check_eq("rst_wdata", wdata_out, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    mem_model[32'h100] = 8'h78;
    mem_model[32'h101] = 8'h56;
    mem_model[32'h102] = 8'h34;
    mem_model[32'h103] = 8'h12;
    mem_model[32'h7] = 8'h80;
    run_op(AluOpLw, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0, 0);
    check_eq("lw_value", wdata_out, 32'h1234_5678);
    run_op(AluOpLb, 32'h7, 32'h0, 5'd4, 1'b1, 32'h0, 0);
    check_eq("lb_value", wdata_out, 32'hffff_ff80);
    run_op(AluOpLbu, 32'h7, 32'h0, 5'd5, 1'b1, 32'h0, 0);
    check_eq("lbu_value", wdata_out, 32'h0000_0080);
    run_op(AluOpSh, 32'h201, 32'haabb_ccdd, 5'd6, 1'b1, 32'h0, 0);
    check_eq("sh_byte0", 32'(get_byte(32'h201)), 32'hdd);
    check_eq("sh_byte1", 32'(get_byte(32'h202)), 32'hcc);
    run_op(AluOpLh, 32'h201, 32'h0, 5'd7, 1'b1, 32'h0, 3);
    check_eq("lh_value", wdata_out, 32'hffff_ccdd);

    // Reset in the middle of a store: only the byte acked before reset may be written.
    run_op(AluOpAddi, 32'h0, 32'h0, 5'd9, 1'b1, 32'h5, 0);
    ack_delay = 0;
    acc_log.delete();
    @(posedge clk);
    #1;
    aluop = AluOpSw;
    addr_in = 32'h300;
    reg2_in = 32'h1122_3344;
    rd_in = 5'd0;
    wreg_in = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    check_eq("mid_rst_addr", mem_bus.addr, 32'd0);
    check_eq("mid_rst_mwdata", 32'(mem_bus.wdata), 32'd0);
    check_eq("mid_rst_wreg", 32'(wreg_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    aluop = AluOpNop;
    @(negedge clk);
    check_eq("post_rst_req", 32'(mem_bus.req), 32'd0);
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("post_rst_req_hold", 32'(mem_bus.req), 32'd0);
    check_eq("abort_writes", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() > 0) begin
      check_eq("abort_addr", acc_log[0].addr, 32'h300);
      check_eq("abort_data", 32'(acc_log[0].data), 32'h44);
    end

    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 8)];
      a = ($urandom_range(0, 3) == 0) ? 32'hffff_fffc + 32'($urandom_range(0, 3)) : $urandom;
      run_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
    end
    @(posedge clk);
    #1;
    aluop = AluOpNop;
    repeat (2) @(negedge clk);
    check_eq("final_idle_req", 32'(mem_bus.req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
